// File: rtl/video_pkg.sv
// Shared video timing definitions: per-axis phase encoding, default
// 640x480@60 timing constants and the raster counter width.
package video_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FRONT  = 2'd1,
        SYNC   = 2'd2,
        BACK   = 2'd3
    } phase_t;

    // Raster counters and pixel positions share this width
    localparam int CNT_W = 10;

    localparam int DEF_CLOCK_DIV = 4;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;

    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

endpackage

// File: rtl/video_timing_axis.sv
// One raster axis: a counter running 0..TOTAL-1 with a phase FSM
// (ACTIVE -> FRONT -> SYNC -> BACK) that always describes the current count.
// o_wrap is high on the advance that takes the counter from TOTAL-1 to 0.
module video_timing_axis
    import video_pkg::*;
#(
    parameter int ACTIVE_LEN = 640,
    parameter int FRONT_LEN  = 16,
    parameter int SYNC_LEN   = 96,
    parameter int BACK_LEN   = 48
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic             i_advance,
    output logic [CNT_W-1:0] o_count,
    output phase_t           o_phase,
    output logic             o_wrap
);

    // Last count of each phase; the phase changes on the advance leaving it
    localparam logic [CNT_W-1:0] END_ACTIVE = CNT_W'(ACTIVE_LEN - 1);
    localparam logic [CNT_W-1:0] END_FRONT  = CNT_W'(ACTIVE_LEN + FRONT_LEN - 1);
    localparam logic [CNT_W-1:0] END_SYNC   = CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN - 1);
    localparam logic [CNT_W-1:0] END_TOTAL  =
        CNT_W'(ACTIVE_LEN + FRONT_LEN + SYNC_LEN + BACK_LEN - 1);

    assign o_wrap = i_advance && (o_count == END_TOTAL);

    // Counter and phase FSM advance together so the phase matches the count
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_count <= '0;
            o_phase <= ACTIVE;
        end else if (i_advance) begin
            if (o_count == END_TOTAL) begin
                o_count <= '0;
                o_phase <= ACTIVE;
            end else begin
                o_count <= o_count + CNT_W'(1);
                case (o_phase)
                    ACTIVE:  if (o_count == END_ACTIVE) o_phase <= FRONT;
                    FRONT:   if (o_count == END_FRONT)  o_phase <= SYNC;
                    SYNC:    if (o_count == END_SYNC)   o_phase <= BACK;
                    default: o_phase <= o_phase;
                endcase
            end
        end
    end

endmodule

// File: rtl/video_timing_gen.sv
// VGA-style video timing generator. A clock divider produces one pixel tick
// every CLOCK_DIV cycles; horizontal and vertical axes produce sync, request
// and position outputs for the pixel being presented. Pixel colour is sampled
// one tick after the request and presented on the pin-side outputs together
// with equally delayed syncs and data-enable.
// Optional build macro VIDEO_TIMING_SCALE2X_EN: positions report counter/2
// (320x240 source for a 640x480 raster); sync/request/RGB timing unchanged.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int CLOCK_DIV = DEF_CLOCK_DIV,
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP
) (
    input  logic        i_clock,
    input  logic        i_reset,
    output logic        o_video_hsync,
    output logic        o_video_vsync,
    output logic        o_video_request,
    output logic [9:0]  o_video_pos_x,
    output logic [9:0]  o_video_pos_y,
    input  logic [31:0] i_video_rdata,
    output logic        o_vga_hs_n,
    output logic        o_vga_vs_n,
    output logic [7:0]  o_vga_r,
    output logic [7:0]  o_vga_g,
    output logic [7:0]  o_vga_b,
    output logic        o_vga_de,
    output logic        o_vblank,
    output logic        o_frame_irq
);

    localparam int DIV_W   = (CLOCK_DIV > 1) ? $clog2(CLOCK_DIV) : 1;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLOCK_DIV - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_IRQ_LINE = CNT_W'(V_ACTIVE - 1);
    localparam logic [CNT_W-1:0] V_BLANK_AT = CNT_W'(V_ACTIVE);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;
    logic [CNT_W-1:0] h_count;
    logic [CNT_W-1:0] v_count;
    phase_t           h_phase;
    phase_t           v_phase;
    logic             h_wrap;
    logic             v_wrap;
    logic [CNT_W-1:0] v_next_line;
    logic [CNT_W-1:0] v_after_tick;
    logic             active_area;
    logic             unused_rdata_hi;
    logic             unused_v_wrap;

    function automatic logic [CNT_W-1:0] scale_pos(input logic [CNT_W-1:0] c);
`ifdef VIDEO_TIMING_SCALE2X_EN
        return c >> 1;
`else
        return c;
`endif
    endfunction

    assign tick            = (div_cnt == DIV_LAST);
    assign v_next_line     = (v_count == V_LAST) ? '0 : v_count + CNT_W'(1);
    assign v_after_tick    = h_wrap ? v_next_line : v_count;
    assign active_area     = (h_phase == ACTIVE) && (v_phase == ACTIVE);
    assign unused_rdata_hi = ^i_video_rdata[31:24];
    assign unused_v_wrap   = v_wrap;

    // Pixel clock divider: free-running modulo-CLOCK_DIV count
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    video_timing_axis #(
        .ACTIVE_LEN (H_ACTIVE),
        .FRONT_LEN  (H_FP),
        .SYNC_LEN   (H_SYNC),
        .BACK_LEN   (H_BP)
    ) u_h_axis (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_advance (tick),
        .o_count   (h_count),
        .o_phase   (h_phase),
        .o_wrap    (h_wrap)
    );

    video_timing_axis #(
        .ACTIVE_LEN (V_ACTIVE),
        .FRONT_LEN  (V_FP),
        .SYNC_LEN   (V_SYNC),
        .BACK_LEN   (V_BP)
    ) u_v_axis (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_advance (h_wrap),
        .o_count   (v_count),
        .o_phase   (v_phase),
        .o_wrap    (v_wrap)
    );

    // Video side: present the current pixel's sync, request and position;
    // from horizontal FRONT onward pos_y already names the upcoming line.
    // vblank follows the line counter value that holds after this tick.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_video_hsync   <= 1'b0;
            o_video_vsync   <= 1'b0;
            o_video_request <= 1'b0;
            o_video_pos_x   <= '0;
            o_video_pos_y   <= '0;
            o_vblank        <= 1'b0;
        end else if (tick) begin
            o_video_hsync   <= (h_phase == SYNC);
            o_video_vsync   <= (v_phase == SYNC);
            o_video_request <= active_area;
            o_video_pos_x   <= active_area ? scale_pos(h_count) : '0;
            o_video_pos_y   <= (h_phase == ACTIVE) ? scale_pos(v_count)
                                                   : scale_pos(v_next_line);
            o_vblank        <= (v_after_tick >= V_BLANK_AT);
        end
    end

    // Frame interrupt: single-cycle pulse as the line counter enters blanking
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_frame_irq <= 1'b0;
        end else begin
            o_frame_irq <= h_wrap && (v_count == V_IRQ_LINE);
        end
    end

    // Pin side: capture colour for the previous request and delay syncs/DE
    // by the same pixel so everything lines up at the connector
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_vga_hs_n <= 1'b1;
            o_vga_vs_n <= 1'b1;
            o_vga_de   <= 1'b0;
            o_vga_r    <= '0;
            o_vga_g    <= '0;
            o_vga_b    <= '0;
        end else if (tick) begin
            o_vga_hs_n <= ~o_video_hsync;
            o_vga_vs_n <= ~o_video_vsync;
            o_vga_de   <= o_video_request;
            o_vga_r    <= o_video_request ? i_video_rdata[23:16] : 8'd0;
            o_vga_g    <= o_video_request ? i_video_rdata[15:8]  : 8'd0;
            o_vga_b    <= o_video_request ? i_video_rdata[7:0]   : 8'd0;
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen. Full 640-pixel lines with a short
// vertical raster keep whole frames within a small cycle budget.
module tb_video_timing_gen;

    localparam int CD = 2;
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 6,   VF = 2,  VS = 2,  VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;

    typedef logic [51:0] vec_t;
    localparam vec_t RESET_VEC = {3'b000, 20'd0, 2'b00, 3'b110, 24'd0};

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        o_video_hsync, o_video_vsync, o_video_request;
    logic [9:0]  o_video_pos_x, o_video_pos_y;
    logic [31:0] i_video_rdata;
    logic        o_vga_hs_n, o_vga_vs_n, o_vga_de;
    logic [7:0]  o_vga_r, o_vga_g, o_vga_b;
    logic        o_vblank, o_frame_irq;

    always #5 i_clock = ~i_clock;

    video_timing_gen #(
        .CLOCK_DIV (CD),
        .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
        .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB)
    ) dut (
        .i_clock         (i_clock),
        .i_reset         (i_reset),
        .o_video_hsync   (o_video_hsync),
        .o_video_vsync   (o_video_vsync),
        .o_video_request (o_video_request),
        .o_video_pos_x   (o_video_pos_x),
        .o_video_pos_y   (o_video_pos_y),
        .i_video_rdata   (i_video_rdata),
        .o_vga_hs_n      (o_vga_hs_n),
        .o_vga_vs_n      (o_vga_vs_n),
        .o_vga_r         (o_vga_r),
        .o_vga_g         (o_vga_g),
        .o_vga_b         (o_vga_b),
        .o_vga_de        (o_vga_de),
        .o_vblank        (o_vblank),
        .o_frame_irq     (o_frame_irq)
    );

    vec_t sb[$];
    int   checks = 0;
    int   failures = 0;
    bit   mon_en = 1'b0;
    bit   track_en = 1'b0;
    int   first_hs_rise = -1, first_hs_fall = -1, first_vs_rise = -1, first_req_again = -1;
    int   irq_ticks[$];

    function automatic int scl(input int v);
`ifdef VIDEO_TIMING_SCALE2X_EN
        return v / 2;
`else
        return v;
`endif
    endfunction

    // Expected outputs just after pixel tick k, from raster arithmetic
    function automatic vec_t model(input int k, input logic [31:0] rd);
        int x, y, y1, xp, yp;
        logic hs, vs, req, vbl, irq, hsp, vsp, reqp;
        logic [9:0] px, py;
        logic [7:0] r, g, b;
        x   = k % HT;
        y   = (k / HT) % VT;
        y1  = ((k + 1) / HT) % VT;
        hs  = (x >= HA + HF) && (x < HA + HF + HS);
        vs  = (y >= VA + VF) && (y < VA + VF + VS);
        req = (x < HA) && (y < VA);
        px  = req ? 10'(scl(x)) : 10'd0;
        py  = (x < HA) ? 10'(scl(y)) : 10'(scl((y + 1) % VT));
        vbl = (y1 >= VA);
        irq = (x == HT - 1) && (y == VA - 1);
        if (k == 0) begin
            hsp = 1'b0; vsp = 1'b0; reqp = 1'b0;
        end else begin
            xp   = (k - 1) % HT;
            yp   = ((k - 1) / HT) % VT;
            hsp  = (xp >= HA + HF) && (xp < HA + HF + HS);
            vsp  = (yp >= VA + VF) && (yp < VA + VF + VS);
            reqp = (xp < HA) && (yp < VA);
        end
        r = reqp ? rd[23:16] : 8'd0;
        g = reqp ? rd[15:8]  : 8'd0;
        b = reqp ? rd[7:0]   : 8'd0;
        return {hs, vs, req, px, py, vbl, irq, ~hsp, ~vsp, reqp, r, g, b};
    endfunction

    function automatic vec_t actual();
        return {o_video_hsync, o_video_vsync, o_video_request, o_video_pos_x, o_video_pos_y,
                o_vblank, o_frame_irq, o_vga_hs_n, o_vga_vs_n, o_vga_de, o_vga_r, o_vga_g, o_vga_b};
    endfunction

    task automatic check_vec(input string name, input vec_t act, input vec_t exp, input int idx);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s idx=%0d actual=%h required=%h", name, idx, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per pixel tick; between ticks irq must be low
    initial begin : monitor
        int   cyc;
        int   tick_idx;
        vec_t e;
        logic prev_hs, prev_req;
        cyc = 0; prev_hs = 1'b0; prev_req = 1'b0;
        forever begin
            @(posedge i_clock);
            #1;
            if (!mon_en) begin
                cyc = 0; prev_hs = 1'b0; prev_req = 1'b0;
            end else begin
                cyc++;
                if (cyc % CD == 0) begin
                    tick_idx = cyc / CD - 1;
                    if (sb.size() == 0) begin
                        check_int("scoreboard_empty", 0, 1);
                    end else begin
                        e = sb.pop_front();
                        check_vec("tick", actual(), e, tick_idx);
                    end
                    if (track_en) begin
                        if (o_video_hsync && !prev_hs && first_hs_rise < 0) first_hs_rise = tick_idx;
                        if (!o_video_hsync && prev_hs && first_hs_fall < 0) first_hs_fall = tick_idx;
                        if (o_video_vsync && first_vs_rise < 0) first_vs_rise = tick_idx;
                        if (o_video_request && !prev_req && tick_idx > 0 && first_req_again < 0)
                            first_req_again = tick_idx;
                        if (o_frame_irq) irq_ticks.push_back(tick_idx);
                    end
                    prev_hs  = o_video_hsync;
                    prev_req = o_video_request;
                end else begin
                    check_int("irq_between_ticks", int'(o_frame_irq), 0);
                end
            end
        end
    end

    // Release reset and run n pixel ticks, pushing each tick's expectation
    task automatic run(input int n, input bit directed);
        logic [31:0] rd_prev;
        @(negedge i_clock);
        rd_prev       = directed ? 32'h00AABBCC : $urandom;
        i_video_rdata = rd_prev;
        mon_en        = 1'b1;
        i_reset       = 1'b0;
        for (int k = 0; k < n; k++) begin
            sb.push_back(model(k, rd_prev));
            repeat (CD) @(posedge i_clock);
            #2;
            if (directed && k == 1)
                check_int("first_pixel_rgb_de", int'({o_vga_de, o_vga_r, o_vga_g, o_vga_b}),
                          int'({1'b1, 24'hAABBCC}));
            if (directed && k == HA + 1)
                check_int("blank_rgb_de", int'({o_vga_de, o_vga_r, o_vga_g, o_vga_b}), 0);
            rd_prev       = (directed && (k + 1) < HT) ? 32'h00AABBCC : $urandom;
            i_video_rdata = rd_prev;
        end
    endtask

    initial begin : driver
        i_reset       = 1'b1;
        i_video_rdata = 32'd0;
        repeat (3) @(posedge i_clock);
        #1;
        check_vec("reset_state", actual(), RESET_VEC, 0);

        // Two whole frames, then into frame three up to line 3, x = 299
        track_en = 1'b1;
        run(2 * HT * VT + 3 * HT + 300, 1'b1);
        track_en = 1'b0;
        mon_en   = 1'b0;

        // Mid-frame reset applied between clock edges must act at once
        @(negedge i_clock);
        check_int("pre_reset_pos_x", int'(o_video_pos_x), scl(299));
        i_reset = 1'b1;
        #1;
        check_vec("reset_async", actual(), RESET_VEC, 0);
        repeat (3) @(posedge i_clock);
        #1;
        check_vec("reset_held", actual(), RESET_VEC, 0);

        // Restart from pixel (0,0) with random colour data
        run(2 * HT + 50, 1'b0);
        mon_en = 1'b0;

        check_int("hsync_first_rise", first_hs_rise, 656);
        check_int("hsync_first_fall", first_hs_fall, 752);
        check_int("line_wrap_tick", first_req_again, 800);
        check_int("vsync_first_rise", first_vs_rise, HT * (VA + VF));
        check_int("irq_count", irq_ticks.size(), 2);
        if (irq_ticks.size() >= 2) begin
            check_int("irq_first_tick", irq_ticks[0], HT * VA - 1);
            check_int("frame_length", irq_ticks[1] - irq_ticks[0], HT * VT);
        end
        check_int("scoreboard_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
